alu_share_arbiter: RTL
======================

Name: alu_share_arbiter

Overview:
Round-robin scheduler that shares one 32-bit MIPS ALU, with its 4:1 result-select mux, between four requesters. It grants one request at a time, registers that requester's operands and control onto the shared ALU inputs, and drives the 2-bit select. After a fixed latency it captures the result and returns it to the granted requester as a one-cycle response pulse. It sits between the CPU issue stages or coprocessor ports and the shared ALU datapath.

Parameters:
WIDTH, 32, operand/result width in bits
CTRL_W, 4, ALU control field width
ALU_LAT, 1, cycles from operand drive to valid alu_res; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req  in  4  request vector; bit i = requester i has an op pending
req_a  in  4*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  4*WIDTH  operand B, same packing as req_a
req_ctrl  in  4*CTRL_W  ALU control per requester
gnt  out  4  one-hot, one-cycle pulse: request accepted and operands latched
alu_a  out  WIDTH  shared ALU operand A (registered)
alu_b  out  WIDTH  shared ALU operand B (registered)
alu_ctrl  out  CTRL_W  shared ALU control (registered)
alu_sel  out  2  index of current owner; drives the 4:1 result mux select
alu_res  in  WIDTH  ALU result
alu_zero  in  1  ALU zero flag
rsp_valid  out  4  one-hot, one-cycle pulse to the owner when the result is ready
rsp_data  out  WIDTH  captured result; held until the next capture
rsp_zero  out  1  captured zero flag
busy  out  1  high while an op is outstanding

Behaviour:
- Reset (async assert): state=IDLE, ptr=0. The following all go to 0: gnt, rsp_valid, alu_a, alu_b, alu_ctrl, alu_sel, rsp_data, rsp_zero, busy, lat_cnt.
- Reset mid-operation: the outstanding op is dropped and no rsp_valid is issued. Requesters must re-request.
- FSM states: IDLE, EXEC.
- IDLE:
  - If req==0, stay in IDLE.
  - Otherwise, winner = first set bit scanning ptr, ptr+1, ... mod 4.
  - On that same edge: latch req_a/req_b/req_ctrl[winner] into alu_a/alu_b/alu_ctrl, set alu_sel=winner, pulse gnt[winner], set busy=1, set lat_cnt=ALU_LAT, go to EXEC.
- EXEC:
  - Decrement lat_cnt each cycle.
  - On the cycle lat_cnt==1: capture alu_res into rsp_data and alu_zero into rsp_zero, pulse rsp_valid[alu_sel], set ptr=alu_sel+1 (mod 4, wraps 3->0), clear busy, go to IDLE.
- Latency:
  - gnt appears 1 cycle after req is sampled high in IDLE.
  - rsp_valid appears ALU_LAT cycles after gnt.
  - Back-to-back throughput is one op per ALU_LAT+1 cycles.
- Handshake rules:
  - A requester holds req and its operands stable until it sees gnt[i].
  - After gnt, operand changes are ignored.
  - req deasserted before gnt simply withdraws the request.
  - req held high after gnt is treated as a new request.
- Requests arriving during EXEC wait; they are never lost while held.
- alu_a/alu_b/alu_ctrl/alu_sel hold their values in IDLE until the next grant.
- gnt and rsp_valid are never both asserted in the same cycle.
- Fairness: a continuously requesting requester is granted within 4 grants.

Optional Feature:
Macro ALU_SHARE_STATS_EN.
- Defined:
  - Adds input stat_sel[1:0], output stat_cnt[15:0], and input stat_clr.
  - Keeps four 16-bit saturating grant counters, one per requester. The counter for i increments on gnt[i] and sticks at 16'hFFFF.
  - stat_cnt = counter[stat_sel], combinational.
  - stat_clr (synchronous) zeroes all counters; reset also zeroes them.
  - If stat_clr coincides with a gnt, the clear wins.
- Undefined: the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Package alu_share_pkg holds:
  - the state enum (IDLE, EXEC);
  - localparam NREQ=4 and SEL_W=2;
  - the function rr_pick(req, ptr) returning a valid bit and a 2-bit index.
- One sub-module, rr_pick4: a combinational round-robin priority picker (req[3:0], ptr[1:0] -> idx[1:0], any). It is reused by future shared-resource arbiters.

Test Plan:
- req=4'b0001, A=5, B=7, ctrl=ADD, ALU_LAT=1 -> gnt=0001 at cycle 1; alu_sel=0; rsp_valid=0001 at cycle 2 with rsp_data=12 and rsp_zero=0.
- req=4'b1111 held continuously with ptr=0 -> grant order 0,1,2,3,0; each gnt spaced ALU_LAT+1 cycles; no requester starved.
- ptr=3 after serving requester 2, req=4'b0101 -> next grant goes to 0 (wrap), then to 2.
- Requester 1 changes A from 10 to 99 the cycle after gnt[1], with SUB of B=10 -> rsp_data=0 and rsp_zero=1 (latched operand used).
- Reset asserted mid-EXEC with ALU_LAT=3 -> all outputs 0 immediately with no clock edge needed; no rsp_valid; after release, req=4'b0010 is granted with ptr starting at 0.
- With ALU_SHARE_STATS_EN: grant requester 2 three times -> stat_sel=2 reads 3; assert stat_clr -> reads 0; force the counter to 16'hFFFF and grant again -> stays 16'hFFFF.

Source files
------------

// File: rtl/alu_share_arbiter_pkg.sv
// Shared types and the round-robin pick function for the ALU share arbiter.
// Imported by the interface, the picker and the top.
package alu_share_pkg;
    localparam int NREQ  = 4;
    localparam int SEL_W = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic             any;
        logic [SEL_W-1:0] idx;
    } pick_t;

    // Scan from the highest offset down so the lowest offset from ptr wins last.
    function automatic pick_t rr_pick(input logic [NREQ-1:0] req, input logic [SEL_W-1:0] ptr);
        pick_t            p;
        logic [SEL_W-1:0] pos;
        p = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            pos = ptr + SEL_W'(k);
            if (req[pos]) begin
                p.any = 1'b1;
                p.idx = pos;
            end
        end
        return p;
    endfunction
endpackage

// File: rtl/alu_share_arbiter_if.sv
// Requester handshake plus shared-ALU datapath bundle for alu_share_arbiter.
// slave = arbiter side, master = requesters/ALU side.
interface alu_share_arbiter_if
    import alu_share_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
);
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  req_a;
    logic [NREQ*WIDTH-1:0]  req_b;
    logic [NREQ*CTRL_W-1:0] req_ctrl;
    logic [NREQ-1:0]        gnt;
    logic [WIDTH-1:0]       alu_a;
    logic [WIDTH-1:0]       alu_b;
    logic [CTRL_W-1:0]      alu_ctrl;
    logic [SEL_W-1:0]       alu_sel;
    logic [WIDTH-1:0]       alu_res;
    logic                   alu_zero;
    logic [NREQ-1:0]        rsp_valid;
    logic [WIDTH-1:0]       rsp_data;
    logic                   rsp_zero;
    logic                   busy;

    modport slave (
        input  req, req_a, req_b, req_ctrl, alu_res, alu_zero,
        output gnt, alu_a, alu_b, alu_ctrl, alu_sel, rsp_valid, rsp_data, rsp_zero, busy
    );

    modport master (
        output req, req_a, req_b, req_ctrl, alu_res, alu_zero,
        input  gnt, alu_a, alu_b, alu_ctrl, alu_sel, rsp_valid, rsp_data, rsp_zero, busy
    );
endinterface

// File: rtl/alu_share_arbiter_rr_pick4.sv
// Combinational 4-way round-robin priority picker: first set req bit at or after ptr.
module rr_pick4
    import alu_share_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic [1:0] idx,
    output logic       any
);
    pick_t p;

    always_comb p = rr_pick(req, ptr);

    assign idx = p.idx;
    assign any = p.any;
endmodule

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between four requesters with fixed result latency.
// Optional per-requester grant counters are built when ALU_SHARE_STATS_EN is defined.
module alu_share_arbiter
    import alu_share_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int CTRL_W  = 4,
    parameter int ALU_LAT = 1
) (
    input  logic              clk,
    input  logic              reset,
    alu_share_arbiter_if.slave bus
`ifdef ALU_SHARE_STATS_EN
    ,
    input  logic [1:0]        stat_sel,
    input  logic              stat_clr,
    output logic [15:0]       stat_cnt
`endif
);
    state_t            state_reg, state_next;
    logic [SEL_W-1:0]  ptr_reg, ptr_next;
    logic [3:0]        lat_reg, lat_next;
    logic [NREQ-1:0]   gnt_reg, gnt_next;
    logic [NREQ-1:0]   rsp_valid_reg, rsp_valid_next;
    logic [WIDTH-1:0]  alu_a_reg, alu_a_next;
    logic [WIDTH-1:0]  alu_b_reg, alu_b_next;
    logic [CTRL_W-1:0] alu_ctrl_reg, alu_ctrl_next;
    logic [SEL_W-1:0]  alu_sel_reg, alu_sel_next;
    logic [WIDTH-1:0]  rsp_data_reg, rsp_data_next;
    logic              rsp_zero_reg, rsp_zero_next;
    logic              busy_reg, busy_next;

    logic [SEL_W-1:0]  pick_idx;
    logic              pick_any;
    logic [WIDTH-1:0]  a_arr    [NREQ];
    logic [WIDTH-1:0]  b_arr    [NREQ];
    logic [CTRL_W-1:0] ctrl_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign a_arr[gi]    = bus.req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]    = bus.req_b[gi*WIDTH +: WIDTH];
            assign ctrl_arr[gi] = bus.req_ctrl[gi*CTRL_W +: CTRL_W];
        end
    endgenerate

    rr_pick4 u_pick (
        .req (bus.req),
        .ptr (ptr_reg),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        lat_next       = lat_reg;
        gnt_next       = '0;
        rsp_valid_next = '0;
        alu_a_next     = alu_a_reg;
        alu_b_next     = alu_b_reg;
        alu_ctrl_next  = alu_ctrl_reg;
        alu_sel_next   = alu_sel_reg;
        rsp_data_next  = rsp_data_reg;
        rsp_zero_next  = rsp_zero_reg;
        busy_next      = busy_reg;
        case (state_reg)
            IDLE: begin
                if (pick_any) begin
                    alu_a_next    = a_arr[pick_idx];
                    alu_b_next    = b_arr[pick_idx];
                    alu_ctrl_next = ctrl_arr[pick_idx];
                    alu_sel_next  = pick_idx;
                    gnt_next      = NREQ'(1) << pick_idx;
                    busy_next     = 1'b1;
                    lat_next      = 4'(ALU_LAT);
                    state_next    = EXEC;
                end
            end
            EXEC: begin
                lat_next = lat_reg - 4'd1;
                if (lat_reg == 4'd1) begin
                    rsp_data_next  = bus.alu_res;
                    rsp_zero_next  = bus.alu_zero;
                    rsp_valid_next = NREQ'(1) << alu_sel_reg;
                    // Pointer moves past the owner just served, wrapping 3 -> 0.
                    ptr_next       = alu_sel_reg + SEL_W'(1);
                    busy_next      = 1'b0;
                    state_next     = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            lat_reg       <= '0;
            gnt_reg       <= '0;
            rsp_valid_reg <= '0;
            alu_a_reg     <= '0;
            alu_b_reg     <= '0;
            alu_ctrl_reg  <= '0;
            alu_sel_reg   <= '0;
            rsp_data_reg  <= '0;
            rsp_zero_reg  <= 1'b0;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            lat_reg       <= lat_next;
            gnt_reg       <= gnt_next;
            rsp_valid_reg <= rsp_valid_next;
            alu_a_reg     <= alu_a_next;
            alu_b_reg     <= alu_b_next;
            alu_ctrl_reg  <= alu_ctrl_next;
            alu_sel_reg   <= alu_sel_next;
            rsp_data_reg  <= rsp_data_next;
            rsp_zero_reg  <= rsp_zero_next;
            busy_reg      <= busy_next;
        end
    end

    assign bus.gnt       = gnt_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.alu_a     = alu_a_reg;
    assign bus.alu_b     = alu_b_reg;
    assign bus.alu_ctrl  = alu_ctrl_reg;
    assign bus.alu_sel   = alu_sel_reg;
    assign bus.rsp_data  = rsp_data_reg;
    assign bus.rsp_zero  = rsp_zero_reg;
    assign bus.busy      = busy_reg;

`ifdef ALU_SHARE_STATS_EN
    logic [15:0] cnt_arr [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_stat
            logic [15:0] cnt_reg;
            // Clear takes priority over a coincident grant; counts saturate.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_reg <= '0;
                end else if (stat_clr) begin
                    cnt_reg <= '0;
                end else if (gnt_reg[gi] && (cnt_reg != 16'hFFFF)) begin
                    cnt_reg <= cnt_reg + 16'd1;
                end
            end
            assign cnt_arr[gi] = cnt_reg;
        end
    endgenerate

    assign stat_cnt = cnt_arr[stat_sel];
`endif
endmodule
